// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: parameterised data/parity/stop format with a
// 3-sample majority vote per bit and false-start/parity/framing/break flags.
module uart_rx_cfg #(
  parameter int UART_BPS  = 115200,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 po_perr,
  output logic                 po_ferr,
  output logic                 po_break
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int MID          = BAUD_CNT_MAX / 2;
  localparam int CW           = $clog2(BAUD_CNT_MAX);

  generate
    if (BAUD_CNT_MAX < 8) begin : g_bad_baud
      $error("uart_rx_cfg: CLK_FREQ/UART_BPS must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_S0    = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1    = CW'(MID);
  localparam logic [CW-1:0] CNT_VOTE  = CW'(MID + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state_reg;
  logic [2:0]           rx_sync_reg;
  logic [CW-1:0]        baud_cnt_reg;
  logic [3:0]           bit_cnt_reg;
  logic                 samp0_reg;
  logic                 samp1_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit_reg;
  logic                 stop_err_reg;
  logic                 stop_one_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 flag_reg;
  logic                 perr_reg;
  logic                 ferr_reg;
  logic                 break_reg;

  logic          r2;
  logic          r3;
  logic          fall;
  logic          vote_cyc;
  logic          baud_wrap;
  logic          vote;
  logic          data_xor;
  logic          perr_calc;
  logic          ferr_calc;
  logic          break_calc;
  logic [CW-1:0] baud_cnt_adv;

  // rx_sync_reg[0] is r1, [1] is r2, [2] is r3; only r3 is ever sampled.
  assign r2           = rx_sync_reg[1];
  assign r3           = rx_sync_reg[2];
  assign fall         = ~r2 & r3;
  assign vote_cyc     = (baud_cnt_reg == CNT_VOTE);
  assign baud_wrap    = (baud_cnt_reg == CNT_LAST);
  assign baud_cnt_adv = baud_wrap ? '0 : baud_cnt_reg + CW'(1);

  // Third sample is r3 itself in the vote cycle.
  assign vote = (samp0_reg & samp1_reg) | (samp0_reg & r3) | (samp1_reg & r3);

  assign data_xor   = (^shift_reg) ^ par_bit_reg;
  assign perr_calc  = (PARITY == 1) ? ~data_xor :
                      (PARITY == 2) ?  data_xor : 1'b0;
  assign ferr_calc  = stop_err_reg | ~vote;
  assign break_calc = (shift_reg == '0) & ~par_bit_reg & ~stop_one_reg & ~vote;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= IDLE;
      rx_sync_reg  <= 3'b111;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      samp0_reg    <= 1'b1;
      samp1_reg    <= 1'b1;
      shift_reg    <= '0;
      par_bit_reg  <= 1'b0;
      stop_err_reg <= 1'b0;
      stop_one_reg <= 1'b0;
      data_reg     <= '0;
      flag_reg     <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      break_reg    <= 1'b0;
    end else begin
      rx_sync_reg <= {rx_sync_reg[1:0], rx};
      flag_reg    <= 1'b0;
      if (baud_cnt_reg == CNT_S0) samp0_reg <= r3;
      if (baud_cnt_reg == CNT_S1) samp1_reg <= r3;

      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
          par_bit_reg  <= 1'b0;
          stop_err_reg <= 1'b0;
          stop_one_reg <= 1'b0;
          if (fall) state_reg <= START;
        end

        START: begin
          baud_cnt_reg <= baud_cnt_adv;
          if (vote_cyc && vote) begin
            // Line was back high by mid-bit: glitch, not a start bit.
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
          end else if (baud_wrap) begin
            state_reg <= DATA;
          end
        end

        DATA: begin
          baud_cnt_reg <= baud_cnt_adv;
          if (vote_cyc) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
          if (baud_wrap) begin
            if (bit_cnt_reg == DATA_LAST) begin
              bit_cnt_reg <= '0;
              state_reg   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end
        end

        PAR: begin
          baud_cnt_reg <= baud_cnt_adv;
          if (vote_cyc)  par_bit_reg <= vote;
          if (baud_wrap) state_reg   <= STOP;
        end

        STOP: begin
          baud_cnt_reg <= baud_cnt_adv;
          if (vote_cyc) begin
            if (bit_cnt_reg == STOP_LAST) begin
              // Leave at the final vote so a following start edge is not missed.
              data_reg     <= shift_reg;
              flag_reg     <= 1'b1;
              perr_reg     <= perr_calc;
              ferr_reg     <= ferr_calc;
              break_reg    <= break_calc;
              baud_cnt_reg <= '0;
              bit_cnt_reg  <= '0;
              state_reg    <= r3 ? IDLE : WAIT_HIGH;
            end else begin
              stop_err_reg <= ferr_calc;
              stop_one_reg <= stop_one_reg | vote;
            end
          end else if (baud_wrap) begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
          end
        end

        WAIT_HIGH: begin
          baud_cnt_reg <= '0;
          if (r3) state_reg <= IDLE;
        end

        default: begin
          state_reg    <= IDLE;
          baud_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign po_data  = data_reg;
  assign po_flag  = flag_reg;
  assign po_perr  = perr_reg;
  assign po_ferr  = ferr_reg;
  assign po_break = break_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: six parameter sets driven in parallel, checked every
// cycle against frame-level expectations derived from the line format.
module tb_uart_rx_cfg;

  localparam int NI = 6;

  function automatic int cfg_clk(int i);
    case (i)
      0:       return 100_000_000;
      4:       return 2_000_000;
      5:       return 800_000;
      default: return 1_600_000;
    endcase
  endfunction

  function automatic int cfg_bps(int i);
    return (i == 0) ? 115200 : 100_000;
  endfunction

  function automatic int cfg_db(int i);
    case (i)
      1:       return 7;
      4:       return 9;
      5:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_par(int i);
    case (i)
      1:       return 2;
      4:       return 1;
      5:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_sb(int i);
    return (i == 2 || i == 5) ? 2 : 1;
  endfunction

  function automatic int bit_len(int i);
    return cfg_clk(i) / cfg_bps(i);
  endfunction

  // Cycles from the edge after which rx fell to the po_flag cycle.
  function automatic int lat_of(int i);
    int frame_bits;
    frame_bits = 1 + cfg_db(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_sb(i);
    return 4 + (frame_bits - 1) * bit_len(i) + bit_len(i) / 2 + 1;
  endfunction

  function automatic logic [8:0] mask_of(int i);
    return 9'((1 << cfg_db(i)) - 1);
  endfunction

  // Parity bit a correct transmitter sends for data d.
  function automatic logic par_of(int i, logic [8:0] d);
    logic xr;
    xr = ^(d & mask_of(i));
    return (cfg_par(i) == 1) ? ~xr : xr;
  endfunction

  typedef struct {
    int         cyc;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] rst_n;
  logic [NI-1:0] rx_line;
  wire  [NI-1:0] flag_w;
  wire  [NI-1:0] perr_w;
  wire  [NI-1:0] ferr_w;
  wire  [NI-1:0] brk_w;
  wire  [8:0]    data_w [NI];

  int         vectors = 0;
  int         miscompares = 0;
  exp_t       expq [NI][$];
  exp_t       last_exp [NI];
  int         strobe_cnt [NI];
  int         e0 = 0;
  int         first_cyc0 = -1;
  logic [8:0] first_data0 = '0;
  logic       perr_log1 [2];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      localparam int DBL = cfg_db(gi);
      logic [DBL-1:0] d;
      uart_rx_cfg #(
        .UART_BPS (cfg_bps(gi)),
        .CLK_FREQ (cfg_clk(gi)),
        .DATA_BITS(DBL),
        .PARITY   (cfg_par(gi)),
        .STOP_BITS(cfg_sb(gi))
      ) u_dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n[gi]),
        .rx       (rx_line[gi]),
        .po_data  (d),
        .po_flag  (flag_w[gi]),
        .po_perr  (perr_w[gi]),
        .po_ferr  (ferr_w[gi]),
        .po_break (brk_w[gi])
      );
      assign data_w[gi] = 9'(d);
    end
  endgenerate

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push_exp(input int idx, input int c, input logic [8:0] d,
                          input logic p, input logic f, input logic b);
    exp_t x;
    x.cyc = c; x.data = d; x.perr = p; x.ferr = f; x.brk = b;
    expq[idx].push_back(x);
  endtask

  // Drives one frame; speed is the bit period in percent of nominal.
  task automatic send_frame(input int idx, input logic [8:0] d, input bit flip,
                            input bit stop_zero, input int glitch_bit,
                            input int speed, input int gap, input int abort_bit);
    logic       bits [20];
    int         n;
    int         b;
    int         mid;
    int         len;
    logic       p;
    logic       xr;
    logic [8:0] dm;
    b   = bit_len(idx);
    mid = b / 2;
    dm  = d & mask_of(idx);
    xr  = ^dm;
    n   = 0;
    bits[n] = 1'b0; n++;
    for (int k = 0; k < cfg_db(idx); k++) begin
      bits[n] = dm[k]; n++;
    end
    p = 1'b0;
    if (cfg_par(idx) != 0) begin
      p = par_of(idx, dm) ^ flip;
      bits[n] = p; n++;
    end
    for (int s = 0; s < cfg_sb(idx); s++) begin
      bits[n] = ~stop_zero; n++;
    end
    if (abort_bit < 0)
      push_exp(idx, cyc + lat_of(idx), dm,
               (cfg_par(idx) == 0) ? 1'b0 :
               (cfg_par(idx) == 1) ? ~(xr ^ p) : (xr ^ p),
               stop_zero, (dm == 9'd0) && !p && stop_zero);
    for (int k = 0; k < n; k++) begin
      len = ((k + 1) * b * speed) / 100 - (k * b * speed) / 100;
      for (int c = 0; c < len; c++) begin
        if (k == abort_bit && c == mid) begin
          rst_n[idx]   = 1'b0;
          rx_line[idx] = 1'b1;
          repeat (3) step();
          rst_n[idx] = 1'b1;
          return;
        end
        rx_line[idx] = (k == glitch_bit && c == mid) ? ~bits[k] : bits[k];
        step();
      end
    end
    rx_line[idx] = 1'b1;
    repeat (gap) step();
  endtask

  task automatic rand_frames(input int idx, input int count);
    logic [8:0] d;
    bit         flip;
    bit         sz;
    int         g;
    int         gap;
    for (int k = 0; k < count; k++) begin
      d    = 9'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      sz   = ($urandom_range(0, 7) == 0);
      g    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, cfg_db(idx)) : -1;
      gap  = $urandom_range(4, 2 * bit_len(idx));
      send_frame(idx, d, flip, sz, g, 100, gap, -1);
    end
  endtask

  initial begin
    exp_t x;
    for (int i = 0; i < NI; i++) begin
      last_exp[i].data = '0; last_exp[i].perr = 1'b0;
      last_exp[i].ferr = 1'b0; last_exp[i].brk = 1'b0;
      strobe_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (!rst_n[i]) begin
          if (flag_w[i] || perr_w[i] || ferr_w[i] || brk_w[i] || data_w[i] != 9'd0) begin
            miscompares++;
            $display("FAIL reset_outputs inst=%0d cyc=%0d got flag=%b data=%h perr=%b ferr=%b brk=%b want all 0",
                     i, cyc, flag_w[i], data_w[i], perr_w[i], ferr_w[i], brk_w[i]);
          end
          last_exp[i].data = '0; last_exp[i].perr = 1'b0;
          last_exp[i].ferr = 1'b0; last_exp[i].brk = 1'b0;
        end else if (expq[i].size() > 0 && expq[i][0].cyc == cyc) begin
          x = expq[i].pop_front();
          if (!flag_w[i] || data_w[i] != x.data || perr_w[i] != x.perr ||
              ferr_w[i] != x.ferr || brk_w[i] != x.brk) begin
            miscompares++;
            $display("FAIL strobe inst=%0d cyc=%0d got flag=%b data=%h perr=%b ferr=%b brk=%b want flag=1 data=%h perr=%b ferr=%b brk=%b",
                     i, cyc, flag_w[i], data_w[i], perr_w[i], ferr_w[i], brk_w[i],
                     x.data, x.perr, x.ferr, x.brk);
          end
          if (i == 0 && strobe_cnt[0] == 0) begin
            first_cyc0  = cyc;
            first_data0 = data_w[0];
          end
          if (i == 1 && strobe_cnt[1] < 2) perr_log1[strobe_cnt[1]] = perr_w[1];
          strobe_cnt[i]++;
          last_exp[i] = x;
        end else begin
          if (flag_w[i] || data_w[i] != last_exp[i].data || perr_w[i] != last_exp[i].perr ||
              ferr_w[i] != last_exp[i].ferr || brk_w[i] != last_exp[i].brk) begin
            miscompares++;
            $display("FAIL hold inst=%0d cyc=%0d got flag=%b data=%h perr=%b ferr=%b brk=%b want flag=0 data=%h perr=%b ferr=%b brk=%b",
                     i, cyc, flag_w[i], data_w[i], perr_w[i], ferr_w[i], brk_w[i],
                     last_exp[i].data, last_exp[i].perr, last_exp[i].ferr, last_exp[i].brk);
          end
        end
      end
    end
  end

  initial begin
    rst_n   = '0;
    rx_line = '1;
    perr_log1[0] = 1'b1;
    perr_log1[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = '1;
    repeat (2) step();

    // Hand-derived values pinning the model.
    chk("model_latency_8n1_868", lat_of(0), 8251);
    chk("model_latency_7e1_16", lat_of(1), 157);
    chk("model_even_parity_0x35", int'(par_of(1, 9'h035)), 0);
    chk("model_odd_parity_0x1ff", int'(par_of(4, 9'h1FF)), 0);

    fork
      begin
        e0 = cyc;
        send_frame(0, 9'h0A5, 1'b0, 1'b0, -1, 100, 20, -1);
      end
      begin
        send_frame(1, 9'h035, 1'b0, 1'b0, -1, 100, 10, -1);
        send_frame(1, 9'h035, 1'b1, 1'b0, -1, 100, 10, -1);
        rand_frames(1, 10);
      end
      begin
        send_frame(2, 9'h000, 1'b0, 1'b0, -1, 98, 0, -1);
        send_frame(2, 9'h0FF, 1'b0, 1'b0, -1, 98, 0, -1);
        send_frame(2, 9'h055, 1'b0, 1'b0, -1, 98, 32, -1);
        rand_frames(2, 6);
      end
      begin
        rx_line[3] = 1'b0;
        repeat (2) step();
        rx_line[3] = 1'b1;
        repeat (48) step();
        send_frame(3, 9'h0FF, 1'b0, 1'b0, 4, 100, 16, -1);
        send_frame(3, 9'h03C, 1'b0, 1'b1, -1, 100, 32, -1);
        push_exp(3, cyc + lat_of(3), 9'h000, 1'b0, 1'b1, 1'b1);
        rx_line[3] = 1'b0;
        repeat (30 * 16) step();
        rx_line[3] = 1'b1;
        repeat (32) step();
        send_frame(3, 9'h05A, 1'b0, 1'b0, -1, 100, 16, -1);
        send_frame(3, 9'h0C3, 1'b0, 1'b0, -1, 100, 0, 5);
        repeat (32) step();
        send_frame(3, 9'h081, 1'b0, 1'b0, -1, 100, 16, -1);
      end
      begin
        rand_frames(4, 12);
      end
      begin
        rand_frames(5, 12);
      end
    join
    repeat (100) step();

    for (int i = 0; i < NI; i++) chk($sformatf("pending_strobes_inst%0d", i), expq[i].size(), 0);
    chk("inst0_strobe_latency", first_cyc0 - e0, 8251);
    chk("inst0_data_0xa5", int'(first_data0), 'hA5);
    chk("inst1_perr_good_parity", int'(perr_log1[0]), 0);
    chk("inst1_perr_bad_parity", int'(perr_log1[1]), 1);
    chk("inst3_strobe_count", strobe_cnt[3], 5);
    chk("inst2_strobe_count", strobe_cnt[2], 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
